// File: rtl/line_state_filter_pkg.sv
// Shared car package: steering codes consumed by the motor and direction
// stage, plus the line-follower FSM and side encodings.
//
// Contents:
//   steer_e         3-bit steering code driven on line_state_filter.state
//   track_fsm_e     TRACK / SEARCH / REVERSE
//   side_e          side of the line the car last saw (LEFT / RIGHT)
//   LMR_RESET       filtered {L,M,R} loaded on reset (centred on the line)
//   decode_lmr()    {L,M,R} -> steering code, holding on ambiguous patterns
//   search_steer()  steering code used while hunting for a lost line
package line_state_filter_pkg;

  typedef enum logic [2:0] {
    STEER_TURN_LEFT   = 3'd0,
    STEER_TURN_RIGHT  = 3'd1,
    STEER_GO_STRAIGHT = 3'd2,
    STEER_SHARP_LEFT  = 3'd3,
    STEER_SHARP_RIGHT = 3'd4,
    STEER_BACK        = 3'd5
  } steer_e;

  typedef enum logic [1:0] {
    FSM_TRACK   = 2'd0,
    FSM_SEARCH  = 2'd1,
    FSM_REVERSE = 2'd2
  } track_fsm_e;

  typedef enum logic {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } side_e;

  localparam logic [2:0] LMR_RESET = 3'b010;

  // 101 (line under both outer sensors) is ambiguous, so the caller's
  // current code is kept. 000 is handled by the FSM and never decoded.
  function automatic steer_e decode_lmr(input logic [2:0] lmr, input steer_e hold);
    steer_e res;
    case (lmr)
      3'b010, 3'b111: res = STEER_GO_STRAIGHT;
      3'b110:         res = STEER_TURN_LEFT;
      3'b011:         res = STEER_TURN_RIGHT;
      3'b100:         res = STEER_SHARP_LEFT;
      3'b001:         res = STEER_SHARP_RIGHT;
      default:        res = hold;
    endcase
    return res;
  endfunction

  function automatic steer_e search_steer(input side_e side);
    steer_e res;
    if (side == SIDE_LEFT) res = STEER_SHARP_LEFT;
    else                   res = STEER_SHARP_RIGHT;
    return res;
  endfunction

endpackage

// File: rtl/line_state_filter_sig_filter.sv
// sig_filter: one IR sensor channel. Two-flop synchronizer followed by a
// stability filter: the filtered output only flips after the synchronized
// input has disagreed with it for FILTER_CYCLES consecutive cycles.
//
// Parameters:
//   FILTER_CYCLES  consecutive disagreeing cycles needed to accept a change
//   RST_VAL        filtered value loaded on reset
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   raw_i   raw sensor level, asynchronous to clk
//   filt_o  debounced level
module sig_filter
  import line_state_filter_pkg::*;
#(
  parameter int   FILTER_CYCLES = 100000,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds how many disagreeing cycles have already been seen; the
  // current disagreeing cycle is the FILTER_CYCLES-th when cnt_q hits
  // CNT_LAST, so the counter never exceeds CNT_LAST and cannot wrap.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = sync2_q;
      else                   cnt_d  = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/line_state_filter.sv
// line_state_filter: debounces the three IR line sensors and turns the
// filtered {L,M,R} pattern into a steering code. When the line is lost the
// car spins toward the side it last saw the line on, and after LOST_TIMEOUT
// cycles of searching it backs up.
//
// Parameters:
//   FILTER_CYCLES  sensor stability window in cycles
//   LOST_TIMEOUT   cycles spent in SEARCH before REVERSE
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   left_signal    raw left sensor, 1 = on line
//   mid_signal     raw middle sensor, 1 = on line
//   right_signal   raw right sensor, 1 = on line
//   state          registered steering code (steer_e)
//   lost           registered, high while searching or reversing
module line_state_filter
  import line_state_filter_pkg::*;
#(
  parameter int FILTER_CYCLES = 100000,
  parameter int LOST_TIMEOUT  = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_signal,
  input  logic       mid_signal,
  input  logic       right_signal,
  output logic [2:0] state,
  output logic       lost
);

  localparam int LCW = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
  localparam logic [LCW-1:0] LOST_LAST = LCW'(LOST_TIMEOUT - 1);
  localparam logic [LCW-1:0] LOST_ONE  = LCW'(1);

  logic [2:0] raw_lmr;
  logic [2:0] filt_lmr;

  assign raw_lmr = {left_signal, mid_signal, right_signal};

  for (genvar i = 0; i < 3; i++) begin : g_ch
    sig_filter #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .RST_VAL       (LMR_RESET[i])
    ) u_sig_filter (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_lmr[i]),
      .filt_o (filt_lmr[i])
    );
  end

  track_fsm_e     fsm_q, fsm_d;
  steer_e         state_q, state_d;
  logic           lost_q, lost_d;
  side_e          last_side_q, last_side_d;
  logic [LCW-1:0] lost_cnt_q, lost_cnt_d;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    lost_d      = lost_q;
    last_side_d = last_side_q;
    lost_cnt_d  = lost_cnt_q;

    if (filt_lmr[2] && !filt_lmr[0])      last_side_d = SIDE_LEFT;
    else if (filt_lmr[0] && !filt_lmr[2]) last_side_d = SIDE_RIGHT;

    // Any visible line wins over the search timeout, from every state.
    if (filt_lmr != 3'b000) begin
      fsm_d      = FSM_TRACK;
      state_d    = decode_lmr(filt_lmr, state_q);
      lost_d     = 1'b0;
      lost_cnt_d = '0;
    end else begin
      lost_d = 1'b1;
      unique case (fsm_q)
        FSM_TRACK: begin
          fsm_d      = FSM_SEARCH;
          lost_cnt_d = '0;
          state_d    = search_steer(last_side_q);
        end
        FSM_SEARCH: begin
          if (lost_cnt_q == LOST_LAST) begin
            fsm_d   = FSM_REVERSE;
            state_d = STEER_BACK;
          end else begin
            lost_cnt_d = lost_cnt_q + LOST_ONE;
            state_d    = search_steer(last_side_q);
          end
        end
        FSM_REVERSE: state_d = STEER_BACK;
        default: begin
          fsm_d   = FSM_TRACK;
          state_d = STEER_GO_STRAIGHT;
          lost_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= FSM_TRACK;
      state_q     <= STEER_GO_STRAIGHT;
      lost_q      <= 1'b0;
      last_side_q <= SIDE_LEFT;
      lost_cnt_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      lost_q      <= lost_d;
      last_side_q <= last_side_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign state = state_q;
  assign lost  = lost_q;

endmodule

// File: tb/tb_line_state_filter.sv
// Bench for line_state_filter (FILTER_CYCLES=4, LOST_TIMEOUT=16).
// A reference model steps on every clock edge and queues the expected
// {state, lost}; a monitor pops and compares on each falling edge.
module tb_line_state_filter;

  localparam int FC = 4;
  localparam int LT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lsig = 1'b0, msig = 1'b1, rsig = 1'b0;
  logic [2:0] state;
  logic       lost;

  line_state_filter #(.FILTER_CYCLES(FC), .LOST_TIMEOUT(LT)) dut (
    .clk          (clk),
    .rst          (rst),
    .left_signal  (lsig),
    .mid_signal   (msig),
    .right_signal (rsig),
    .state        (state),
    .lost         (lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       lo;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Filter: the filtered bit flips once the last FC synchronized samples
  // (raw input delayed two clocks, zeros right after reset) all disagree
  // with it; samples from before reset do not count.
  // Steering: a visible line decodes directly; a missing line spins toward
  // the last seen side, and after LT-1 further edges of searching backs up.
  logic [2:0] m_filt, m_d1, m_d2, m_out;
  int         m_win[3][$];
  bit         m_tracking, m_side_right, m_lost;
  int         m_lost_cycles;

  function automatic logic [2:0] spec_decode(input logic [2:0] p, input logic [2:0] hold);
    case (p)
      3'b010, 3'b111: return 3'd2;
      3'b110:         return 3'd0;
      3'b011:         return 3'd1;
      3'b100:         return 3'd3;
      3'b001:         return 3'd4;
      default:        return hold;
    endcase
  endfunction

  task automatic model_reset();
    m_filt = 3'b010;
    m_d1 = 3'b000;
    m_d2 = 3'b000;
    for (int i = 0; i < 3; i++) m_win[i].delete();
    m_tracking = 1'b1;
    m_lost_cycles = 0;
    m_side_right = 1'b0;
    m_out = 3'd2;
    m_lost = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [2:0] in_now);
    logic [2:0] p;
    bit         flip;
    p = m_filt;
    if (p != 3'b000) begin
      m_out = spec_decode(p, m_out);
      m_lost = 1'b0;
      m_tracking = 1'b1;
      m_lost_cycles = 0;
    end else if (m_tracking) begin
      m_tracking = 1'b0;
      m_lost_cycles = 0;
      m_lost = 1'b1;
      m_out = m_side_right ? 3'd4 : 3'd3;
    end else begin
      m_lost = 1'b1;
      if (m_lost_cycles >= LT - 1) m_out = 3'd5;
      else begin
        m_lost_cycles++;
        m_out = m_side_right ? 3'd4 : 3'd3;
      end
    end
    if (p[2] && !p[0])      m_side_right = 1'b0;
    else if (p[0] && !p[2]) m_side_right = 1'b1;

    for (int i = 0; i < 3; i++) begin
      m_win[i].push_front(int'(m_d2[i]));
      if (m_win[i].size() > FC) void'(m_win[i].pop_back());
      flip = (m_win[i].size() == FC);
      for (int k = 0; k < m_win[i].size(); k++)
        if (m_win[i][k] == int'(m_filt[i])) flip = 1'b0;
      if (flip) m_filt[i] = ~m_filt[i];
    end
    m_d2 = m_d1;
    m_d1 = in_now;
    exp_q.push_back({m_out, m_lost});
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step({lsig, msig, rsig});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin : mon
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_state", int'(state), int'(e.st));
        check("sb_lost", int'(lost), int'(e.lo));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] p);
    {lsig, msig, rsig} = p;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for the outputs to reach st/lo; n = falling edges waited.
  task automatic wait_for(input string name, input logic [2:0] st, input logic lo,
                          input int budget, output int n);
    n = 0;
    while (!(state == st && lost == lo)) begin
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL %s timeout: state %0d lost %0d after %0d cycles, wanted state %0d lost %0d",
                 name, state, lost, n, st, lo);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int         n;
    bit         seen_back;
    logic [2:0] p;
    int         hold;

    rst = 1'b1;
    drive(3'b010);
    cyc(3);
    #1;
    check("reset_state", int'(state), 2);
    check("reset_lost", int'(lost), 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Centred on the line: straight ahead, never lost.
    cyc(20);
    check("hold_010_state", int'(state), 2);
    check("hold_010_lost", int'(lost), 0);

    // 110 reaches the output exactly 2 + FC + 1 cycles later.
    drive(3'b110);
    wait_for("turn_left", 3'd0, 1'b0, 20, n);
    check("latency_110", n, FC + 3);
    cyc(5);

    // A glitch shorter than the window is ignored.
    drive(3'b100);
    cyc(FC - 1);
    drive(3'b110);
    cyc(15);
    check("glitch_state", int'(state), 0);

    // Lose the line off the left edge, time out, recover on the right.
    drive(3'b100);
    wait_for("sharp_left", 3'd3, 1'b0, 20, n);
    cyc(4);
    drive(3'b000);
    wait_for("search_left", 3'd3, 1'b1, 20, n);
    wait_for("reverse", 3'd5, 1'b1, 30, n);
    check("search_to_reverse", n, LT);
    drive(3'b001);
    wait_for("recover_right", 3'd4, 1'b0, 20, n);

    // Lost toward the right; 101 while searching returns to tracking and
    // keeps the search steering code.
    cyc(3);
    drive(3'b000);
    wait_for("search_right", 3'd4, 1'b1, 20, n);
    drive(3'b101);
    wait_for("track_101", 3'd4, 1'b0, 20, n);
    check("latency_101", n, FC + 3);
    cyc(5);
    check("hold_101_state", int'(state), 4);

    // Line reappears in the very cycle the search counter reaches LT-1.
    drive(3'b100);
    wait_for("sharp_left2", 3'd3, 1'b0, 20, n);
    cyc(3);
    drive(3'b000);
    wait_for("search_left2", 3'd3, 1'b1, 20, n);
    cyc(LT - FC - 2 - 1);
    drive(3'b010);
    seen_back = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (state == 3'd5) seen_back = 1'b1;
    end
    check("race_no_back", int'(seen_back), 0);
    check("race_state", int'(state), 2);
    check("race_lost", int'(lost), 0);

    // Reset while reversing acts immediately and restores last_side LEFT.
    drive(3'b001);
    wait_for("sharp_right", 3'd4, 1'b0, 20, n);
    cyc(3);
    drive(3'b000);
    wait_for("reverse2", 3'd5, 1'b1, 40, n);
    cyc(2);
    #3 rst = 1'b1;
    #1;
    check("async_rst_state", int'(state), 2);
    check("async_rst_lost", int'(lost), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_for("post_rst_search", 3'd3, 1'b1, 20, n);

    // Random patterns and hold times, with occasional mid-run resets.
    for (int s = 0; s < 300; s++) begin
      @(negedge clk);
      p = 3'($urandom_range(0, 7));
      hold = (p == 3'b000) ? $urandom_range(1, 24) : $urandom_range(1, 10);
      drive(p);
      if ($urandom_range(0, 39) == 0) begin
        #3 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
      cyc(hold);
    end

    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_state_filter.md
LINE_STATE_FILTER -- requirements
Module: line_state_filter

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, 100000, consecutive stable cycles required to accept a sensor change (1 ms at 100 MHz).
REQ-002 SHALL have parameter LOST_TIMEOUT, 50000000, cycles in SEARCH before REVERSE (0.5 s).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port left_signal  input  1  raw IR sensor; 1 = on line; asynchronous to clk.
REQ-006 SHALL have port mid_signal  input  1  raw IR sensor; 1 = on line; asynchronous to clk.
REQ-007 SHALL have port right_signal  input  1  raw IR sensor; 1 = on line; asynchronous to clk.
REQ-008 SHALL have port state  output  3  steering code consumed by the motor and direction stage.
REQ-009 SHALL have port lost  output  1  high while in SEARCH or REVERSE.

Function
REQ-010 SHALL use these state codes: turn_left=0, turn_right=1, go_straight=2, sharp_turn_left=3, sharp_turn_right=4, back=5; codes 6-7 are never driven.
REQ-011 SHALL pass each raw input through a 2-flop synchronizer.
REQ-012 SHALL update each filtered bit only after its synchronized value has differed from the filtered value for FILTER_CYCLES consecutive cycles; any reversion restarts that channel's count at 0.
REQ-013 SHALL register state and lost, giving input-to-state latency = 2 + FILTER_CYCLES + 1 cycles.
REQ-014 SHALL run FSM states TRACK, SEARCH and REVERSE.
REQ-015 In TRACK, SHALL decode filtered {L,M,R} as: 010 or 111 -> go_straight; 110 -> turn_left; 011 -> turn_right; 100 -> sharp_turn_left; 001 -> sharp_turn_right; 101 -> hold the previous state.
REQ-016 SHALL keep a last_side register: set LEFT when filtered L=1 and R=0, set RIGHT when R=1 and L=0, otherwise unchanged.
REQ-017 In TRACK, filtered 000 SHALL move the FSM to SEARCH on the next cycle.
REQ-018 On entry to SEARCH, SHALL clear the lost counter.
REQ-019 In SEARCH, SHALL output sharp_turn_left if last_side=LEFT, else sharp_turn_right.
REQ-020 In SEARCH, the lost counter SHALL increment each cycle; when it reaches LOST_TIMEOUT-1, the FSM SHALL move to REVERSE and output back.
REQ-021 In SEARCH or REVERSE, any nonzero filtered pattern SHALL return the FSM to TRACK and decode per REQ-015 in the same transition; for pattern 101, SHALL hold the current output.
REQ-022 When a nonzero pattern and counter = LOST_TIMEOUT-1 occur in the same cycle, TRACK SHALL win.
REQ-023 The lost counter SHALL saturate and never wrap; its width is $clog2(LOST_TIMEOUT).
REQ-024 Filter counters SHALL be $clog2(FILTER_CYCLES+1) bits wide and SHALL not wrap.

Reset
REQ-025 On rst, SHALL asynchronously clear the synchronizers to 0.
REQ-026 On rst, SHALL load filtered {L,M,R}=010 so start-up is go_straight, not lost.
REQ-027 On rst, SHALL clear the filter counters and lost counter to 0.
REQ-028 On rst, SHALL set last_side=LEFT, FSM=TRACK, state=2 (go_straight), lost=0.
REQ-029 Reset asserted mid-SEARCH or mid-REVERSE SHALL return all registers to REQ-025..028 values immediately; no partial state survives.
REQ-030 Deassertion SHALL be synchronized externally; the block itself requires no release sequencing.

Structure
REQ-031 State codes (REQ-010) SHALL live in the shared car package or header, which the motor and direction stage also uses.
REQ-032 SHALL implement one sub-module, sig_filter (synchronizer plus stability counter, parameter FILTER_CYCLES), instantiated three times.
REQ-033 The FSM, last_side register, lost counter and decode SHALL reside in line_state_filter.

Verification (FILTER_CYCLES=4, LOST_TIMEOUT=16)
REQ-034 Reset, then hold inputs 010 -> state=2, lost=0 throughout.
REQ-035 Change inputs to 110 -> state=0 exactly 7 cycles later; a 3-cycle glitch to 100 -> no state change.
REQ-036 Inputs 100 then 000 -> lost=1 and state=3; after 16 further cycles -> state=5; then inputs 001 -> state=4, lost=0.
REQ-037 Inputs 001 then 000 -> state=4; pattern 101 during SEARCH -> TRACK, state stays 4, lost=0.
REQ-038 Make filtered 010 arrive on the cycle the counter reaches 15 -> state=2, never 5.
REQ-039 Assert rst during REVERSE -> state=2 and lost=0 asynchronously; inputs 000 afterwards -> state=3 (last_side reset to LEFT).
